stopwatch_chain_counter: RTL
============================

Name: stopwatch_chain_counter

Overview:
Parametrised cascade of modulo-N digit counters for the watch/stopwatch datapath. It replaces the hand-written single-digit mod-2/mod-6/mod-10 counters with one block. Features:
- any number of digits, each with its own modulus
- up/down counting, preset load
- wrap or saturate at the end of range
- lap (display freeze) capture
It sits between the 1 Hz / 100 Hz tick generator and the 7-segment display mux.

Parameters:
DIGITS, 4, number of cascaded digits; digit 0 is least significant.
DIGIT_W, 4, bits per digit.
MOD_VEC, 16'h6A6A, packed per-digit moduli; digit i uses MOD_VEC[i*DIGIT_W +: DIGIT_W]. Legal range is 2..2^DIGIT_W-1. The default gives mm:ss (10,6,10,6).
SATURATE, 0, selects end-of-range behaviour: 0 = wrap, 1 = hold at max (up) or at zero (down).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
tick_en  in  1  single-cycle advance strobe
run  in  1  level signal: 1 = counting enabled (start/resume), 0 = paused
clear  in  1  synchronous clear of count and lap state
down  in  1  direction: 0 = up, 1 = down
load  in  1  preset strobe
load_val  in  DIGITS*DIGIT_W  preset value
lap  in  1  lap strobe; toggles display freeze
count  out  DIGITS*DIGIT_W  live count register
display  out  DIGITS*DIGIT_W  lap_reg while frozen, otherwise count (combinational mux)
frozen  out  1  lap hold active
carry_out  out  1  registered pulse when the whole chain wraps
at_max  out  1  all digits equal to modulus-1 (combinational from count)
at_zero  out  1  count is all zero (combinational from count)

Behaviour:
- Reset values: count=0, lap_reg=0, frozen=0, carry_out=0. Therefore display=0, at_zero=1, at_max=0.
- Priority in every cycle: reset > clear > load > count step.
- clear:
  - Sets count=0, lap_reg=0, frozen=0.
  - A tick in the same cycle is ignored.
- load:
  - Each digit i takes min(load_val digit, mod_i-1); out-of-range digits are clamped.
  - frozen and lap_reg are unaffected.
  - A tick in the same cycle is ignored.
- Step condition: run && tick_en && !clear && !load. A tick while run=0 is dropped and not queued.
- Up step:
  - Digit 0 increments.
  - Digit i (i>0) increments only when every lower digit is at mod-1 in the same step.
  - A digit at mod-1 that steps goes to 0.
- Down step:
  - Mirror of the up step: digit i decrements when every lower digit is 0.
  - A digit at 0 that steps goes to mod-1.
- Latency: count updates on the clock edge that samples the tick. carry_out is high in the following cycle for exactly 1 cycle.
- Wrap, SATURATE=0:
  - An up step from all-max gives all-zero with carry_out=1.
  - A down step from all-zero gives all-max with carry_out=1.
- Saturate, SATURATE=1:
  - An up step at all-max (or a down step at all-zero) leaves count unchanged.
  - carry_out stays 0.
- lap:
  - If frozen=0: lap_reg <= count as it was before any same-cycle step, and frozen <= 1.
  - If frozen=1: frozen <= 0 and lap_reg is retained.
  - Counting continues underneath in both cases.
- Simultaneous lap and clear: clear wins and frozen=0.
- Simultaneous lap and load: both take effect. The capture uses the pre-load count.
- Reset mid-run: the next cycle is the reset state. run is not latched, so counting resumes as soon as reset falls with run=1 and tick_en arriving.
- down may change between ticks. A direction change takes effect on the next step with no extra latency.

Decomposition:
- Package stopwatch_pkg holds:
  - DIGIT_W default
  - MOD_MMSS (16'h6A6A) and MOD_HHMMSS constants
  - the function that extracts a modulus field from MOD_VEC
  - the clamp function
- Sub-module mod_digit, one instance per digit via generate.
  - Inputs: clk, reset, clear, load, load_digit, modulus, step, down.
  - Outputs: value, is_max, is_zero.
- The top level holds:
  - the ripple-enable chain (AND of lower is_max / is_zero)
  - the saturate gating
  - the carry register
  - the lap logic

Test Plan:
1. Defaults, run=1. Load 16'h5959, then one tick. Expect count=16'h0000 one edge later, carry_out=1 for exactly the next cycle, at_zero=1.
2. down=1 from count=0, one tick. Expect count=16'h5959 and a carry_out pulse. Repeat with SATURATE=1: count stays 0 and carry_out stays 0.
3. load with load_val=16'h7B99. Expect count=16'h5959 (clamped). Assert load and tick together: the tick is ignored.
4. Run 25 ticks from 0 (count=16'h0025). Pulse lap: display stays 16'h0025 while count reaches 16'h0030 after 5 more ticks. Pulse lap again: display=16'h0030 and frozen=0.
5. run=0 with 10 ticks: count unchanged. Set run=1 and tick: count increments by 1 only.
6. Assert clear together with lap and tick at count=16'h0042 while frozen: count=0, frozen=0, display=0. Assert reset mid-run: all outputs at their reset values the next cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants, types and helper functions for the stopwatch digit chain.
package stopwatch_pkg;

    // Default width of one digit field.
    localparam int DIGIT_W_DEF = 4;

    // Per-digit moduli, least significant digit in the lowest nibble.
    // mm:ss -> 10, 6, 10, 6
    localparam logic [15:0] MOD_MMSS   = 16'h6A6A;
    // hh:mm:ss -> 10, 6, 10, 6, 10, 3 (hours tens digit limited to 0..2)
    localparam logic [23:0] MOD_HHMMSS = 24'h3A6A6A;

    // Widest modulus vector the extraction helper accepts.
    localparam int MAX_VEC_W = 256;

    // Lap display state: live count shown, or captured lap value held.
    typedef enum logic {
        LAP_LIVE = 1'b0,
        LAP_HELD = 1'b1
    } lap_state_t;

    // Pull the modulus of digit idx out of a packed modulus vector.
    function automatic logic [31:0] mod_field(input logic [MAX_VEC_W-1:0] vec,
                                              input int idx,
                                              input int width);
        logic [MAX_VEC_W-1:0] shifted;
        logic [31:0]          mask;
        shifted = vec >> (idx * width);
        mask    = (32'd1 << width) - 32'd1;
        return shifted[31:0] & mask;
    endfunction

    // Limit a preset digit to the top of its range (modulus - 1).
    function automatic logic [31:0] clamp_digit(input logic [31:0] value,
                                                input logic [31:0] modulus);
        return (value >= modulus) ? (modulus - 32'd1) : value;
    endfunction

endpackage

// File: rtl/stopwatch_chain_counter_mod_digit.sv
// One modulo-N digit: clear, clamped preset, and single up/down step.
module mod_digit
    import stopwatch_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_digit,
    input  logic [W-1:0] modulus,
    input  logic         step,
    input  logic         down,
    output logic [W-1:0] value,
    output logic         is_max,
    output logic         is_zero
);

    assign is_max  = (value == (modulus - W'(1)));
    assign is_zero = (value == '0);

    // Digit register: reset and clear win over preset, preset wins over a step.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (load) begin
            value <= W'(clamp_digit(32'(load_digit), 32'(modulus)));
        end else if (step) begin
            if (down) begin
                value <= is_zero ? (modulus - W'(1)) : (value - W'(1));
            end else begin
                value <= is_max ? '0 : (value + W'(1));
            end
        end
    end

endmodule

// File: rtl/stopwatch_chain_counter.sv
// Cascade of modulo-N digits with up/down, preset, wrap/saturate and lap freeze.
module stopwatch_chain_counter
    import stopwatch_pkg::*;
#(
    parameter int                        DIGITS   = 4,
    parameter int                        DIGIT_W  = DIGIT_W_DEF,
    parameter logic [DIGITS*DIGIT_W-1:0] MOD_VEC  = MOD_MMSS,
    parameter bit                        SATURATE = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick_en,
    input  logic                      run,
    input  logic                      clear,
    input  logic                      down,
    input  logic                      load,
    input  logic [DIGITS*DIGIT_W-1:0] load_val,
    input  logic                      lap,
    output logic [DIGITS*DIGIT_W-1:0] count,
    output logic [DIGITS*DIGIT_W-1:0] display,
    output logic                      frozen,
    output logic                      carry_out,
    output logic                      at_max,
    output logic                      at_zero
);

    logic [DIGITS-1:0]         dig_max;
    logic [DIGITS-1:0]         dig_zero;
    logic [DIGITS-1:0]         up_en;
    logic [DIGITS-1:0]         dn_en;
    logic [DIGITS-1:0]         dig_step;
    logic                      step_req;
    logic                      end_hit;
    logic                      step_go;
    logic                      carry_next;
    logic [DIGITS*DIGIT_W-1:0] lap_reg;
    logic                      capture;
    lap_state_t                lap_state;
    lap_state_t                lap_next;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            localparam logic [DIGIT_W-1:0] MOD_I =
                DIGIT_W'(mod_field(MAX_VEC_W'(MOD_VEC), gi, DIGIT_W));

            mod_digit #(
                .W (DIGIT_W)
            ) u_digit (
                .clk        (clk),
                .reset      (reset),
                .clear      (clear),
                .load       (load),
                .load_digit (load_val[gi*DIGIT_W +: DIGIT_W]),
                .modulus    (MOD_I),
                .step       (dig_step[gi]),
                .down       (down),
                .value      (count[gi*DIGIT_W +: DIGIT_W]),
                .is_max     (dig_max[gi]),
                .is_zero    (dig_zero[gi])
            );
        end
    endgenerate

    assign at_max  = &dig_max;
    assign at_zero = (count == '0);

    assign step_req   = run && tick_en && !clear && !load;
    assign end_hit    = down ? at_zero : at_max;
    assign step_go    = step_req && !(SATURATE && end_hit);
    assign carry_next = step_req && end_hit && !SATURATE;

    // Ripple enables: a digit moves only when every lower digit is at its turnover value.
    always_comb begin
        up_en    = '0;
        dn_en    = '0;
        dig_step = '0;
        up_en[0] = 1'b1;
        dn_en[0] = 1'b1;
        for (int i = 1; i < DIGITS; i++) begin
            up_en[i] = up_en[i-1] & dig_max[i-1];
            dn_en[i] = dn_en[i-1] & dig_zero[i-1];
        end
        for (int i = 0; i < DIGITS; i++) begin
            dig_step[i] = step_go && (down ? dn_en[i] : up_en[i]);
        end
    end

    // Whole-chain turnover pulse, one cycle after the stepping edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_out <= 1'b0;
        end else begin
            carry_out <= carry_next;
        end
    end

    // Lap state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            lap_state <= LAP_LIVE;
        end else begin
            lap_state <= lap_next;
        end
    end

    // Lap toggle: capture on entry to hold, release on the next lap; clear forces live.
    always_comb begin
        lap_next = lap_state;
        capture  = 1'b0;
        if (clear) begin
            lap_next = LAP_LIVE;
        end else if (lap) begin
            case (lap_state)
                LAP_LIVE: begin
                    lap_next = LAP_HELD;
                    capture  = 1'b1;
                end
                LAP_HELD: begin
                    lap_next = LAP_LIVE;
                end
                default: begin
                    lap_next = LAP_LIVE;
                end
            endcase
        end
    end

    // Lap value holds the count as it stood before any same-cycle step or preset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lap_reg <= '0;
        end else if (clear) begin
            lap_reg <= '0;
        end else if (capture) begin
            lap_reg <= count;
        end
    end

    assign frozen  = (lap_state == LAP_HELD);
    assign display = frozen ? lap_reg : count;

endmodule
